// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V core writeback path.
//   RES_*   : encodings of the 3:1 result-mux select (ALU / data memory / PC+4)
//   state_t : writeback sequencer state encoding (2 bits)
package riscv_pkg;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MEM  = 2'b01,
        ST_WB   = 2'b10,
        ST_ERR  = 2'b11
    } state_t;

endpackage

// File: rtl/wb_sequencer.sv
// Writeback sequencer of the RISC-V core.
// Drives the result-mux select, the regfile write enable and the PC stall.
// Non-memory instructions retire in the cycle they are presented; loads and
// stores run a req/ready handshake with a variable-latency data memory and
// stall the PC until the access completes or times out.
//
// Handshake: mem_req rises on the first MEM cycle and stays high every cycle
// until a cycle in which mem_ready=1 (transfer completes on that rising edge)
// or until the timeout aborts the access. mem_we qualifies mem_req and is
// constant for the whole access. mem_ready outside MEM is ignored.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   instr_valid       decoded instruction present (sampled only in IDLE)
//   is_load/is_store  memory instruction class (never both 1)
//   is_link           JAL/JALR: write PC+4 to rd
//   rd_write          decoder says instruction writes rd
//   mem_ready         data memory completes access this cycle
//   mem_req, mem_we   data memory request / write strobe
//   result_src        00 ALU, 01 MEM, 10 PC+4
//   reg_write         regfile write enable
//   pc_stall          hold PC / fetch
//   mem_err           one-cycle pulse when an access is aborted by timeout
//   dbg_state         current sequencer state (debug observation)
module wb_sequencer
    import riscv_pkg::*;
#(
    parameter int TIMEOUT = 15, // max MEM cycles waiting for mem_ready (>=1)
    parameter int CNT_W   = 4   // 2**CNT_W must exceed TIMEOUT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       instr_valid,
    input  logic       is_load,
    input  logic       is_store,
    input  logic       is_link,
    input  logic       rd_write,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic [1:0] result_src,
    output logic       reg_write,
    output logic       pc_stall,
    output logic       mem_err,
    output logic [1:0] dbg_state
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_op_store;
    logic             w_is_mem;

    assign w_is_mem  = is_load | is_store;
    assign dbg_state = r_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_op_store <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (instr_valid && w_is_mem) begin
                        r_op_store <= is_store;
                        r_cnt      <= '0;
                        r_state    <= ST_MEM;
                    end
                end
                ST_MEM: begin
                    // Completion wins over timeout when both happen together.
                    if (mem_ready) begin
                        r_state <= r_op_store ? ST_IDLE : ST_WB;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= ST_ERR;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_WB:   r_state <= ST_IDLE;
                ST_ERR:  r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Output decode. Gated by rst_n so every output is 0 while reset is held,
    // even if the decoder keeps presenting an instruction.
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        result_src = RES_ALU;
        reg_write  = 1'b0;
        pc_stall   = 1'b0;
        mem_err    = 1'b0;
        if (rst_n) begin
            case (r_state)
                ST_IDLE: begin
                    if (instr_valid) begin
                        if (w_is_mem) begin
                            // Request is issued from the next cycle on.
                            pc_stall = 1'b1;
                        end else begin
                            result_src = is_link ? RES_PC4 : RES_ALU;
                            reg_write  = rd_write;
                        end
                    end
                end
                ST_MEM: begin
                    mem_req  = 1'b1;
                    mem_we   = r_op_store;
                    // A store retires in its completion cycle; a load still
                    // needs the WB cycle, so the PC stays held.
                    pc_stall = ~(mem_ready & r_op_store);
                end
                ST_WB: begin
                    result_src = RES_MEM;
                    reg_write  = 1'b1;
                end
                ST_ERR: begin
                    mem_err = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_sequencer.sv
module tb_wb_sequencer;
    import riscv_pkg::*;

    localparam int TIMEOUT = 15;
    localparam int W       = 9;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       instr_valid, is_load, is_store, is_link, rd_write, mem_ready;
    logic       mem_req, mem_we, reg_write, pc_stall, mem_err;
    logic [1:0] result_src, dbg_state;

    wb_sequencer #(.TIMEOUT(TIMEOUT), .CNT_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .instr_valid(instr_valid),
        .is_load    (is_load),
        .is_store   (is_store),
        .is_link    (is_link),
        .rd_write   (rd_write),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .result_src (result_src),
        .reg_write  (reg_write),
        .pc_stall   (pc_stall),
        .mem_err    (mem_err),
        .dbg_state  (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    // scoreboard
    logic [W-1:0] exp_q[$];
    string        nm_q[$];
    int           n_chk = 0;
    int           n_err = 0;

    function automatic logic [W-1:0] ex(input logic req, input logic we,
                                        input logic [1:0] src, input logic rw,
                                        input logic stall, input logic err,
                                        input logic [1:0] st);
        return {req, we, src, rw, stall, err, st};
    endfunction

    function automatic logic [W-1:0] obs();
        return {mem_req, mem_we, result_src, reg_write, pc_stall, mem_err, dbg_state};
    endfunction

    task automatic check(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got {req,we,src,rw,stall,err,st}=%b expected %b at %0t",
                     nm, got, exp, $time);
        end
    endtask

    // Compare once per cycle, 2 time units after inputs change on the falling edge.
    always begin
        @(negedge clk);
        #2;
        if (exp_q.size() > 0) check(nm_q.pop_front(), obs(), exp_q.pop_front());
    end

    // driver: present inputs for one cycle and record the expected outputs
    task automatic drive(input string nm, input logic v, input logic ld, input logic st,
                         input logic lk, input logic rw, input logic mr,
                         input logic [W-1:0] e);
        @(negedge clk);
        instr_valid = v; is_load = ld; is_store = st;
        is_link = lk; rd_write = rw; mem_ready = mr;
        exp_q.push_back(e);
        nm_q.push_back(nm);
    endtask

    task automatic idle_cycle(input string nm);
        drive(nm, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ex(0, 0, RES_ALU, 0, 0, 0, ST_IDLE));
    endtask

    // Memory access: ready on MEM cycle n (1..TIMEOUT), n=0 means never.
    task automatic mem_seq(input string nm, input logic st, input int n);
        logic rdy;
        logic done;
        done = 1'b0;
        drive({nm, "_idle"}, 1'b1, ~st, st, 1'b0, 1'b1, 1'b0,
              ex(0, 0, RES_ALU, 0, 1, 0, ST_IDLE));
        for (int k = 1; k <= TIMEOUT; k++) begin
            if (!done) begin
                rdy = (k == n);
                drive($sformatf("%s_mem%0d", nm, k), 1'b1, ~st, st, 1'b0, 1'b1, rdy,
                      ex(1, st, RES_ALU, 0, ~(rdy & st), 0, ST_MEM));
                done = rdy;
            end
        end
        if (!done)
            drive({nm, "_err"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                  ex(0, 0, RES_ALU, 0, 0, 1, ST_ERR));
        else if (!st)
            drive({nm, "_wb"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                  ex(0, 0, RES_MEM, 1, 0, 0, ST_WB));
        idle_cycle({nm, "_after"});
    endtask

    typedef struct {
        logic         v;
        logic         lk;
        logic         rw;
        logic         mr;
        logic [W-1:0] e;
    } vec_t;

    vec_t tbl[8];

    initial begin
        // single-cycle retire vectors (non-memory instructions in IDLE)
        tbl[0] = '{1'b1, 1'b0, 1'b1, 1'b0, ex(0, 0, RES_ALU, 1, 0, 0, ST_IDLE)}; // ADD
        tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b0, ex(0, 0, RES_PC4, 1, 0, 0, ST_IDLE)}; // JAL
        tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b0, ex(0, 0, RES_ALU, 0, 0, 0, ST_IDLE)}; // branch
        tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b0, ex(0, 0, RES_PC4, 0, 0, 0, ST_IDLE)}; // JAL x0
        tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b0, ex(0, 0, RES_ALU, 0, 0, 0, ST_IDLE)}; // bubble
        tbl[5] = '{1'b0, 1'b1, 1'b1, 1'b1, ex(0, 0, RES_ALU, 0, 0, 0, ST_IDLE)}; // stray ready
        tbl[6] = '{1'b1, 1'b0, 1'b1, 1'b1, ex(0, 0, RES_ALU, 1, 0, 0, ST_IDLE)}; // ADD, stray ready
        tbl[7] = '{1'b1, 1'b1, 1'b1, 1'b1, ex(0, 0, RES_PC4, 1, 0, 0, ST_IDLE)}; // JALR, stray ready

        rst_n = 1'b0;
        instr_valid = 1'b0; is_load = 1'b0; is_store = 1'b0;
        is_link = 1'b0; rd_write = 1'b0; mem_ready = 1'b0;
        #1;
        check("reset_out", obs(), '0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_hold", obs(), '0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++)
            drive($sformatf("tbl%0d", i), tbl[i].v, 1'b0, 1'b0, tbl[i].lk, tbl[i].rw,
                  tbl[i].mr, tbl[i].e);

        // load, ready on 3rd MEM cycle
        mem_seq("load3", 1'b0, 3);
        // store, ready on 1st MEM cycle
        mem_seq("store1", 1'b1, 1);
        // load, never ready -> timeout, then again back to back
        mem_seq("load_to", 1'b0, 0);
        mem_seq("load_to2", 1'b0, 0);
        // load, ready on last allowed cycle
        mem_seq("load15", 1'b0, TIMEOUT);
        // store timeout and store at last cycle
        mem_seq("store_to", 1'b1, 0);
        mem_seq("store15", 1'b1, TIMEOUT);
        // random latencies
        for (int i = 0; i < 4; i++) begin
            int n;
            logic st;
            n  = $urandom_range(1, TIMEOUT);
            st = 1'($urandom_range(0, 1));
            mem_seq($sformatf("rnd%0d", i), st, n);
        end

        // reset in MEM cycle 2
        drive("rst_idle", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, ex(0, 0, RES_ALU, 0, 1, 0, ST_IDLE));
        drive("rst_mem1", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, ex(1, 0, RES_ALU, 0, 1, 0, ST_MEM));
        drive("rst_mem2", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, ex(1, 0, RES_ALU, 0, 1, 0, ST_MEM));
        #3;
        rst_n = 1'b0;
        #1;
        check("reset_mid", obs(), '0);
        @(posedge clk);
        #1;
        check("reset_mid_hold", obs(), '0);
        @(negedge clk);
        rst_n = 1'b1;
        instr_valid = 1'b0; is_load = 1'b0;
        drive("post_rst_add", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ex(0, 0, RES_ALU, 1, 0, 0, ST_IDLE));
        idle_cycle("post_rst_idle");

        // drain the scoreboard with a bounded wait
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        #3;
        n_chk++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
